fwd_scoreboard: RTL and testbench

//  Parametrised forwarding/hazard unit for the pipelined core. It holds its own

---
 rtl/fwd_scoreboard_pkg.sv | 20 ++
 rtl/fwd_src_match.sv | 49 ++++
 rtl/fwd_scoreboard.sv | 101 ++++++++++
 tb/tb_fwd_scoreboard.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared definitions for the forwarding scoreboard: entry status flags and the
// stall counter width, also used by the hazard/decode logic.
package fwd_scoreboard_pkg;

  localparam int STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

  // Status bits of one tracked stage; rd/data live in separate arrays
  typedef struct packed {
    logic v;
    logic we;
    logic ld;
    logic rdy;
  } ent_flags_t;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] cnt);
    return (cnt == STALL_CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// One source operand compared against all tracked stages; the youngest match
// decides between forwarding its value and requesting a stall.
module fwd_src_match #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int DEPTH  = 2
) (
  input  logic                      src_valid,
  input  logic [REG_AW-1:0]         src_addr,
  input  logic [DEPTH-1:0]          ent_v,
  input  logic [DEPTH-1:0]          ent_we,
  input  logic [DEPTH-1:0]          ent_rdy,
  input  logic [DEPTH*REG_AW-1:0]   ent_rd,
  input  logic [DEPTH*DATA_W-1:0]   ent_data,
  output logic                      hit,
  output logic [DATA_W-1:0]         data,
  output logic                      stall_req
);

  logic [DEPTH-1:0] match;
  logic             found;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign match[gi] = src_valid & ent_v[gi] & ent_we[gi] &
                         (ent_rd[gi*REG_AW +: REG_AW] == src_addr);
    end
  endgenerate

  // First match from stage 0 wins, even if it is not ready yet
  always_comb begin
    hit       = 1'b0;
    data      = '0;
    stall_req = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k] && !found) begin
        found = 1'b1;
        if (ent_rdy[k]) begin
          hit  = 1'b1;
          data = ent_data[k*DATA_W +: DATA_W];
        end else begin
          stall_req = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard unit: tracks the last DEPTH instructions to leave EX and
// forwards the youngest matching result or stalls on a not-yet-ready load.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int LD_LAT  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_valid,
  input  logic                       ex_wr_en,
  input  logic                       ex_is_load,
  input  logic [REG_AW-1:0]          ex_rd,
  input  logic [DATA_W-1:0]          ex_result,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       flush,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*REG_AW-1:0]  src_addr,
  output logic [NUM_SRC-1:0]         fwd_hit,
  output logic [NUM_SRC*DATA_W-1:0]  fwd_data,
  output logic                       stall,
  output logic [STALL_CNT_W-1:0]     stall_cnt
);

  ent_flags_t              flag_reg [DEPTH];
  logic [REG_AW-1:0]       rd_reg   [DEPTH];
  logic [DATA_W-1:0]       data_reg [DEPTH];
  logic [STALL_CNT_W-1:0]  stall_cnt_reg;

  logic [DEPTH-1:0]        ent_v, ent_we, ent_rdy;
  logic [DEPTH*REG_AW-1:0] ent_rd;
  logic [DEPTH*DATA_W-1:0] ent_data;
  logic [NUM_SRC-1:0]      stall_req;
  logic                    stall_int;
  logic                    capture;

  assign stall_int = |stall_req;
  assign capture   = ex_valid & ~stall_int & ~flush;

  // The pipe keeps draining during a stall; only the EX capture is blocked
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) flag_reg[k] <= '0;
      stall_cnt_reg <= '0;
    end else begin
      flag_reg[0] <= capture ? '{v: 1'b1, we: ex_wr_en, ld: ex_is_load, rdy: ~ex_is_load}
                             : '0;
      if (capture) begin
        rd_reg[0]   <= ex_rd;
        data_reg[0] <= ex_result;
      end
      for (int k = 1; k < DEPTH; k++) begin
        flag_reg[k] <= flag_reg[k-1];
        rd_reg[k]   <= rd_reg[k-1];
        data_reg[k] <= data_reg[k-1];
        if (k == LD_LAT && flag_reg[k-1].v && flag_reg[k-1].ld) begin
          flag_reg[k].rdy <= 1'b1;
          data_reg[k]     <= ld_data;
        end
      end
      if (stall_int) stall_cnt_reg <= sat_inc(stall_cnt_reg);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign ent_v[gi]                      = flag_reg[gi].v;
      assign ent_we[gi]                     = flag_reg[gi].we;
      assign ent_rdy[gi]                    = flag_reg[gi].rdy;
      assign ent_rd[gi*REG_AW +: REG_AW]    = rd_reg[gi];
      assign ent_data[gi*DATA_W +: DATA_W]  = data_reg[gi];
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_src_match #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
      ) u_match (
        .src_valid (src_valid[gi]),
        .src_addr  (src_addr[gi*REG_AW +: REG_AW]),
        .ent_v     (ent_v),
        .ent_we    (ent_we),
        .ent_rdy   (ent_rdy),
        .ent_rd    (ent_rd),
        .ent_data  (ent_data),
        .hit       (fwd_hit[gi]),
        .data      (fwd_data[gi*DATA_W +: DATA_W]),
        .stall_req (stall_req[gi])
      );
    end
  endgenerate

  assign stall     = stall_int;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: default configuration plus a
// NUM_SRC=3 / DEPTH=4 / LD_LAT=2 instance for the parameter sweep.
module tb_fwd_scoreboard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ex_valid, ex_wr_en, ex_is_load, flush;
  logic [2:0]  ex_rd;
  logic [15:0] ex_result, ld_data;
  logic [1:0]  src_valid, fwd_hit;
  logic [5:0]  src_addr;
  logic [31:0] fwd_data;
  logic        stall;
  logic [15:0] stall_cnt;

  logic        p_ex_valid, p_ex_wr_en, p_ex_is_load, p_flush;
  logic [2:0]  p_ex_rd;
  logic [15:0] p_ex_result, p_ld_data;
  logic [2:0]  p_src_valid, p_fwd_hit;
  logic [8:0]  p_src_addr;
  logic [47:0] p_fwd_data;
  logic        p_stall;
  logic [15:0] p_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fwd_scoreboard dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .ld_data(ld_data), .flush(flush), .src_valid(src_valid), .src_addr(src_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .stall(stall), .stall_cnt(stall_cnt)
  );

  fwd_scoreboard #(.DATA_W(16), .REG_AW(3), .NUM_SRC(3), .DEPTH(4), .LD_LAT(2)) dut_p (
    .clk(clk), .rst(rst), .ex_valid(p_ex_valid), .ex_wr_en(p_ex_wr_en),
    .ex_is_load(p_ex_is_load), .ex_rd(p_ex_rd), .ex_result(p_ex_result),
    .ld_data(p_ld_data), .flush(p_flush), .src_valid(p_src_valid), .src_addr(p_src_addr),
    .fwd_hit(p_fwd_hit), .fwd_data(p_fwd_data), .stall(p_stall), .stall_cnt(p_stall_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input logic v, input logic we, input logic ld,
                        input logic [2:0] rd, input logic [15:0] res);
    ex_valid = v; ex_wr_en = we; ex_is_load = ld; ex_rd = rd; ex_result = res;
  endtask

  task automatic p_ex_set(input logic v, input logic we, input logic ld,
                          input logic [2:0] rd, input logic [15:0] res);
    p_ex_valid = v; p_ex_wr_en = we; p_ex_is_load = ld; p_ex_rd = rd; p_ex_result = res;
  endtask

  initial begin
    rst = 1'b0;
    ex_set(0, 0, 0, 3'd0, 16'h0);
    p_ex_set(0, 0, 0, 3'd0, 16'h0);
    flush = 0; ld_data = 0; src_valid = 0; src_addr = 0;
    p_flush = 0; p_ld_data = 0; p_src_valid = 0; p_src_addr = 0;
    tick(); tick();
    rst = 1'b1;

    // reset state
    src_valid = 2'b11; src_addr = {3'd0, 3'd0};
    p_src_valid = 3'b111; p_src_addr = {3'd0, 3'd0, 3'd0};
    #1;
    check_val("rst_hit", 64'(fwd_hit), 64'h0);
    check_val("rst_data", 64'(fwd_data), 64'h0);
    check_val("rst_stall", 64'(stall), 64'h0);
    check_val("rst_cnt", 64'(stall_cnt), 64'h0);
    check_val("rst_p_stall", 64'(p_stall), 64'h0);
    check_val("rst_p_hit", 64'(p_fwd_hit), 64'h0);
    src_valid = 0; p_src_valid = 0;

    // 1: ALU chain
    ex_set(1, 1, 0, 3'd1, 16'h0005);
    tick();
    ex_set(0, 0, 0, 3'd0, 16'h0);
    src_valid = 2'b01; src_addr = {3'd0, 3'd1};
    #1;
    check_val("alu_hit", 64'(fwd_hit[0]), 64'h1);
    check_val("alu_data", 64'(fwd_data[15:0]), 64'h0005);
    check_val("alu_stall", 64'(stall), 64'h0);

    // 2: youngest match wins, then older write drains out
    src_valid = 0;
    ex_set(1, 1, 0, 3'd2, 16'h1111);
    tick();
    ex_set(1, 1, 0, 3'd2, 16'h2222);
    tick();
    ex_set(0, 0, 0, 3'd0, 16'h0);
    src_valid = 2'b01; src_addr = {3'd0, 3'd2};
    #1;
    check_val("prio_hit", 64'(fwd_hit[0]), 64'h1);
    check_val("prio_data", 64'(fwd_data[15:0]), 64'h2222);
    tick();
    check_val("drain_data", 64'(fwd_data[15:0]), 64'h2222);

    // 3: load-use, LD_LAT=1
    src_valid = 0;
    ex_set(1, 1, 1, 3'd3, 16'h9999);
    tick();
    ex_set(1, 1, 0, 3'd5, 16'h5555);
    src_valid = 2'b10; src_addr = {3'd3, 3'd0};
    ld_data = 16'h0000;
    #1;
    check_val("lu_stall", 64'(stall), 64'h1);
    check_val("lu_hit", 64'(fwd_hit), 64'h0);
    ld_data = 16'hBEEF;
    tick();
    ex_set(0, 0, 0, 3'd0, 16'h0);
    ld_data = 16'h0000;
    #1;
    check_val("lu_done_stall", 64'(stall), 64'h0);
    check_val("lu_done_hit", 64'(fwd_hit[1]), 64'h1);
    check_val("lu_done_data", 64'(fwd_data[31:16]), 64'hBEEF);
    check_val("lu_cnt", 64'(stall_cnt), 64'h1);
    src_valid = 2'b01; src_addr = {3'd3, 3'd5};
    #1;
    check_val("lu_bubble", 64'(fwd_hit[0]), 64'h0);

    // 4: qualifiers (we=0, v=0, src_valid=0)
    src_valid = 0;
    ex_set(1, 0, 0, 3'd6, 16'h0066);
    tick();
    ex_set(0, 1, 0, 3'd7, 16'h0077);
    tick();
    ex_set(0, 0, 0, 3'd0, 16'h0);
    src_valid = 2'b01; src_addr = {3'd0, 3'd6};
    #1;
    check_val("we0_hit", 64'(fwd_hit), 64'h0);
    check_val("we0_data", 64'(fwd_data), 64'h0);
    check_val("we0_stall", 64'(stall), 64'h0);
    src_addr = {3'd0, 3'd7};
    #1;
    check_val("v0_hit", 64'(fwd_hit), 64'h0);
    src_valid = 0;
    ex_set(1, 1, 0, 3'd1, 16'h0777);
    tick();
    ex_set(0, 0, 0, 3'd0, 16'h0);
    src_addr = {3'd1, 3'd1};
    #1;
    check_val("srcv0_hit", 64'(fwd_hit), 64'h0);
    check_val("srcv0_data", 64'(fwd_data), 64'h0);
    src_valid = 2'b11;
    #1;
    check_val("both_hit", 64'(fwd_hit), 64'h3);
    check_val("both_data", 64'(fwd_data), 64'h0777_0777);

    // 5: flush kills capture; reset during a load-use stall
    src_valid = 0;
    ex_set(1, 1, 0, 3'd4, 16'h0044);
    flush = 1;
    tick();
    flush = 0;
    ex_set(0, 0, 0, 3'd0, 16'h0);
    src_valid = 2'b01; src_addr = {3'd0, 3'd4};
    #1;
    check_val("flush_hit", 64'(fwd_hit), 64'h0);
    src_valid = 0;
    ex_set(1, 1, 1, 3'd3, 16'h0);
    tick();
    ex_set(0, 0, 0, 3'd0, 16'h0);
    src_valid = 2'b10; src_addr = {3'd3, 3'd0};
    #1;
    check_val("mid_stall", 64'(stall), 64'h1);
    check_val("mid_cnt", 64'(stall_cnt), 64'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_val("rst2_stall", 64'(stall), 64'h0);
    check_val("rst2_cnt", 64'(stall_cnt), 64'h0);
    check_val("rst2_hit", 64'(fwd_hit), 64'h0);
    src_valid = 0;

    // 6: NUM_SRC=3, DEPTH=4, LD_LAT=2
    p_ex_set(1, 1, 1, 3'd2, 16'h9999);
    tick();
    p_ex_set(0, 0, 0, 3'd0, 16'h0);
    p_src_valid = 3'b111; p_src_addr = {3'd2, 3'd2, 3'd2};
    p_ld_data = 16'h1234;
    #1;
    check_val("p_stall_c1", 64'(p_stall), 64'h1);
    check_val("p_hit_c1", 64'(p_fwd_hit), 64'h0);
    tick();
    check_val("p_stall_c2", 64'(p_stall), 64'h1);
    check_val("p_hit_c2", 64'(p_fwd_hit), 64'h0);
    p_ld_data = 16'hCAFE;
    tick();
    p_ld_data = 16'h0000;
    #1;
    check_val("p_stall_c3", 64'(p_stall), 64'h0);
    check_val("p_hit_c3", 64'(p_fwd_hit), 64'h7);
    check_val("p_data_c3", 64'(p_fwd_data), 64'hCAFE_CAFE_CAFE);
    check_val("p_cnt", 64'(p_stall_cnt), 64'h2);
    tick();
    check_val("p_data_c4", 64'(p_fwd_data), 64'hCAFE_CAFE_CAFE);
    check_val("p_cnt_c4", 64'(p_stall_cnt), 64'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
